key_seq_ctrl: RTL and testbench

Bus-side sequencer for the key/serial PAL mapped in the 0x1xxx window. When the host starts a readout, the block arbitrates for the backplane address bus, replays a programmable sequence of NSTEPS read cycles with BA7..BA4 taken from an internal nibble table, and samples the PAL's two tri-stated data bits (SDRD, p12) on each cycle. The sampled bits are collected into two result words, and the bus is released when the sequence ends.

---
 rtl/key_seq_ctrl_if.sv | 31 +++
 rtl/key_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_key_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_seq_ctrl_if.sv
// Backplane/PAL side of the key sequencer: address-bus arbitration, BA7..BA4 drive and the
// PAL strobe with its two returned data bits.
interface key_seq_ctrl_if;
    logic       bus_req;
    logic       bus_gnt;
    logic [3:0] ba;
    logic       ba_oe;
    logic       sser_n;
    logic       sdrd_in;
    logic       p12_in;

    modport master (
        output bus_req,
        output ba,
        output ba_oe,
        output sser_n,
        input  bus_gnt,
        input  sdrd_in,
        input  p12_in
    );

    modport slave (
        input  bus_req,
        input  ba,
        input  ba_oe,
        input  sser_n,
        output bus_gnt,
        output sdrd_in,
        output p12_in
    );
endinterface

// File: rtl/key_seq_ctrl.sv
// Key/serial PAL sequencer: wins the address bus, replays a nibble table onto BA7..BA4 for
// NSTEPS read cycles and collects the PAL's SDRD/p12 bits into key_d/key_p.
module key_seq_ctrl #(
    parameter int unsigned NSTEPS   = 16,
    parameter int unsigned STRB_CYC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tbl_we,
    input  logic [3:0]     tbl_idx,
    input  logic [3:0]     tbl_nib,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [15:0]    key_d,
    output logic [15:0]    key_p,
    key_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StSetup,
        StStrobe,
        StRecover,
        StDone
    } state_e;

    localparam logic [3:0] LastStep = 4'(NSTEPS - 1);
    localparam logic [2:0] LastStrb = 3'(STRB_CYC - 1);

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [2:0]  strb_q, strb_d;
    logic [15:0] key_d_q, key_d_d;
    logic [15:0] key_p_q, key_p_d;
    logic [3:0]  tbl_q [16];
    logic        bus_req_q, ba_oe_q, sser_n_q, done_q;
    logic [3:0]  ba_q;
    logic        drive_d;

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign key_d       = key_d_q;
    assign key_p       = key_p_q;
    assign bus.bus_req = bus_req_q;
    assign bus.ba_oe   = ba_oe_q;
    assign bus.ba      = ba_q;
    assign bus.sser_n  = sser_n_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        strb_d  = strb_q;
        key_d_d = key_d_q;
        key_p_d = key_p_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StReq;
                    step_d  = '0;
                    key_d_d = '0;
                    key_p_d = '0;
                end
            end
            StReq: begin
                if (bus.bus_gnt) state_d = StSetup;
            end
            StSetup: begin
                state_d = StStrobe;
                strb_d  = '0;
            end
            StStrobe: begin
                // Grant is deliberately ignored here; a started PAL cycle always completes.
                if (strb_q == LastStrb) begin
                    key_d_d[step_q] = bus.sdrd_in;
                    key_p_d[step_q] = bus.p12_in;
                    state_d         = StRecover;
                end else begin
                    strb_d = strb_q + 3'd1;
                end
            end
            StRecover: begin
                if (step_q == LastStep) begin
                    state_d = StDone;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = bus.bus_gnt ? StSetup : StReq;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort beats everything, including a sample landing on the same edge.
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            step_d  = step_q;
            key_d_d = key_d_q;
            key_p_d = key_p_q;
        end
    end

    assign drive_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StRecover);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            strb_q  <= '0;
            key_d_q <= '0;
            key_p_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            strb_q  <= strb_d;
            key_d_q <= key_d_d;
            key_p_q <= key_p_d;
        end
    end

    // Bus outputs are registered from the next state so the PAL clock never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_q <= 1'b0;
            ba_oe_q   <= 1'b0;
            ba_q      <= '0;
            sser_n_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            bus_req_q <= (state_d == StReq) || drive_d;
            ba_oe_q   <= drive_d;
            ba_q      <= drive_d ? tbl_q[step_d] : 4'h0;
            sser_n_q  <= (state_d != StStrobe);
            done_q    <= (state_d == StDone);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) tbl_q[i] <= '0;
        end else if (tbl_we && !busy) begin
            tbl_q[tbl_idx] <= tbl_nib;
        end
    end

endmodule

// File: tb/tb_key_seq_ctrl.sv
// Bench for key_seq_ctrl: a PAL model that steps on sser_n rising edges, a bus arbiter model
// and a table shadow predict ba, sample contents and sequence length.
module tb_key_seq_ctrl;

    localparam int StrbA = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_we, a_start, a_abort;
    logic [3:0]  a_idx, a_nib;
    logic        a_busy, a_done;
    logic [15:0] a_kd, a_kp;
    key_seq_ctrl_if bus_a();

    logic        b_we, b_start, b_abort;
    logic [3:0]  b_idx, b_nib;
    logic        b_busy, b_done;
    logic [15:0] b_kd, b_kp;
    key_seq_ctrl_if bus_b();

    key_seq_ctrl u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .tbl_we  (a_we),
        .tbl_idx (a_idx),
        .tbl_nib (a_nib),
        .start   (a_start),
        .abort   (a_abort),
        .busy    (a_busy),
        .done    (a_done),
        .key_d   (a_kd),
        .key_p   (a_kp),
        .bus     (bus_a)
    );

    key_seq_ctrl #(
        .NSTEPS   (4),
        .STRB_CYC (1)
    ) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .tbl_we  (b_we),
        .tbl_idx (b_idx),
        .tbl_nib (b_nib),
        .start   (b_start),
        .abort   (b_abort),
        .busy    (b_busy),
        .done    (b_done),
        .key_d   (b_kd),
        .key_p   (b_kp),
        .bus     (bus_b)
    );

    int errors = 0;
    int checks = 0;
    logic [3:0] shadow [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input int idx, input logic [3:0] nib);
        a_we  = 1'b1;
        a_idx = 4'(idx);
        a_nib = nib;
        tick();
        a_we = 1'b0;
        shadow[idx] = nib;
    endtask

    // One sequence on DUT A. drop_step/drop_len: grant low for drop_len clocks from that step's
    // RECOVER. abort_cyc: busy-cycle number (1 = first REQ clock) carrying abort, 0 for none.
    task automatic run_a(input int init_wait, input int drop_step, input int drop_len,
                         input int abort_cyc, input logic [15:0] pat_d,
                         input logic [15:0] pat_p, input bit rnd);
        logic [15:0] exp_d, exp_p;
        int          cyc, pal_cnt, low_run, drop_left, exp_cyc, wi;
        logic        prev_sser, prev_oe, chk_req, rising, fin;
        logic [3:0]  prev_ba, wnib;
        exp_d     = '0;
        exp_p     = '0;
        cyc       = 0;
        pal_cnt   = 0;
        low_run   = 0;
        drop_left = init_wait;
        chk_req   = 1'b0;
        fin       = 1'b0;
        exp_cyc   = 1 + init_wait + 16 * (StrbA + 2) + 1 + ((drop_step < 15) ? drop_len : 0);
        if (rnd) begin
            wi          = $urandom_range(15);
            wnib        = 4'($urandom);
            a_we        = 1'b1;
            a_idx       = 4'(wi);
            a_nib       = wnib;
            shadow[wi]  = wnib;
        end
        a_start          = 1'b1;
        bus_a.bus_gnt    = 1'b1;
        bus_a.sdrd_in    = pat_d[0];
        bus_a.p12_in     = pat_p[0];
        prev_sser        = 1'b1;
        prev_oe          = 1'b0;
        prev_ba          = 4'h0;
        tick();
        a_we    = 1'b0;
        a_start = 1'b0;
        while (!fin) begin
            cyc++;
            rising = !prev_sser && bus_a.sser_n;
            if (chk_req) begin
                check("rearb_req", 32'({bus_a.bus_req, bus_a.ba_oe}), 32'h2);
                chk_req = 1'b0;
            end
            if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
                check("abort_idle", 32'({a_busy, a_done, bus_a.bus_req, bus_a.ba_oe,
                                         bus_a.sser_n}), 32'h01);
                check("abort_key_d", 32'(a_kd), 32'(exp_d));
                check("abort_key_p", 32'(a_kp), 32'(exp_p));
                fin = 1'b1;
            end else if (!a_busy) begin
                check("busy_dropped_no_done", 32'(cyc), 32'(exp_cyc + 1000));
                fin = 1'b1;
            end else if (cyc > exp_cyc + 20) begin
                check("timeout", 32'(cyc), 32'(exp_cyc));
                fin = 1'b1;
            end else begin
                if (rising) begin
                    check("strobe_len", 32'(low_run), 32'(StrbA));
                    check("recover_ba", 32'({bus_a.ba_oe, bus_a.ba}), 32'({1'b1, prev_ba}));
                    pal_cnt++;
                    if (pal_cnt - 1 == drop_step && drop_len > 0 && drop_step < 15) begin
                        drop_left = drop_len;
                        chk_req   = 1'b1;
                    end
                end
                if (prev_sser && !bus_a.sser_n) begin
                    check("setup_oe", 32'(prev_oe), 32'h1);
                    check("ba_setup_stable", 32'(bus_a.ba), 32'(prev_ba));
                    check("ba_table", 32'(bus_a.ba), 32'(shadow[pal_cnt[3:0]]));
                    low_run = 0;
                end
                if (!bus_a.sser_n) begin
                    low_run++;
                    check("strobe_oe", 32'({bus_a.ba_oe, bus_a.bus_req}), 32'h3);
                end
                if (a_done) begin
                    check("seq_cycles", 32'(cyc), 32'(exp_cyc));
                    check("key_d", 32'(a_kd), 32'(exp_d));
                    check("key_p", 32'(a_kp), 32'(exp_p));
                    check("pal_steps", 32'(pal_cnt), 32'd16);
                    fin = 1'b1;
                end
            end
            if (!fin) begin
                a_abort = (cyc == abort_cyc);
                if (!bus_a.sser_n && low_run == StrbA && !a_abort) begin
                    exp_d[pal_cnt[3:0]] = pat_d[pal_cnt[3:0]];
                    exp_p[pal_cnt[3:0]] = pat_p[pal_cnt[3:0]];
                end
                bus_a.sdrd_in = pat_d[pal_cnt[3:0]];
                bus_a.p12_in  = pat_p[pal_cnt[3:0]];
                if (drop_left > 0) begin
                    bus_a.bus_gnt = 1'b0;
                    drop_left--;
                end else if (!bus_a.sser_n && rnd) begin
                    bus_a.bus_gnt = 1'($urandom);
                end else begin
                    bus_a.bus_gnt = 1'b1;
                end
                a_we      = 1'($urandom);
                a_idx     = 4'($urandom);
                a_nib     = 4'h9;
                a_start   = 1'($urandom);
                prev_sser = bus_a.sser_n;
                prev_oe   = bus_a.ba_oe;
                prev_ba   = bus_a.ba;
                tick();
            end
        end
        a_abort       = 1'b0;
        a_we          = 1'b0;
        a_start       = 1'b0;
        bus_a.bus_gnt = 1'b1;
        tick();
        if (abort_cyc == 0) begin
            check("post_done_idle", 32'({a_busy, a_done}), 32'h0);
            check("key_hold", 32'(a_kd), 32'(exp_d));
        end
    endtask

    task automatic run_b();
        int cyc;
        bus_b.sdrd_in = 1'b1;
        bus_b.p12_in  = 1'b0;
        bus_b.bus_gnt = 1'b1;
        b_start       = 1'b1;
        tick();
        b_start = 1'b0;
        cyc     = 1;
        while (!b_done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("b_cycles", 32'(cyc), 32'd14);
        check("b_key_d", 32'(b_kd), 32'h000F);
        check("b_key_p", 32'(b_kp), 32'h0000);
        tick();
        check("b_idle", 32'({b_busy, b_done}), 32'h0);
    endtask

    initial begin
        a_we = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_idx = '0; a_nib = '0;
        b_we = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_idx = '0; b_nib = '0;
        bus_a.bus_gnt = 1'b1; bus_a.sdrd_in = 1'b0; bus_a.p12_in = 1'b0;
        bus_b.bus_gnt = 1'b1; bus_b.sdrd_in = 1'b0; bus_b.p12_in = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_ctrl_a", 32'({a_busy, a_done, bus_a.bus_req, bus_a.ba_oe, bus_a.sser_n}),
              32'h01);
        check("rst_ba_a", 32'(bus_a.ba), 32'h0);
        check("rst_key_a", 32'({a_kd, a_kp}), 32'h0);
        check("rst_ctrl_b", 32'({b_busy, b_done, bus_b.bus_req, bus_b.ba_oe, bus_b.sser_n}),
              32'h01);

        // start and abort together in IDLE: stays IDLE
        a_start = 1'b1;
        a_abort = 1'b1;
        tick();
        a_start = 1'b0;
        a_abort = 1'b0;
        check("start_abort_idle", 32'({a_busy, bus_a.bus_req}), 32'h0);

        for (int i = 0; i < 16; i++) tbl_write(i, 4'(i));
        run_a(0, 99, 0, 0, 16'hAAAA, 16'h5555, 1'b0);
        run_a(0, 7, 4, 0, 16'hAAAA, 16'h5555, 1'b0);
        run_a(0, 99, 0, 16, 16'hFFFF, 16'h00FF, 1'b0);
        run_a(0, 99, 0, 64, 16'hFFFF, 16'hFFFF, 1'b0);
        for (int n = 0; n < 8; n++) begin
            run_a($urandom_range(3), $urandom_range(15), $urandom_range(4),
                  ($urandom_range(3) == 0) ? $urandom_range(60) + 1 : 0,
                  16'($urandom), 16'($urandom), 1'b1);
        end

        // Reset mid-sequence (during step 5) must clear everything asynchronously.
        bus_a.sdrd_in = 1'b1;
        bus_a.p12_in  = 1'b1;
        a_start       = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (22) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl", 32'({a_busy, a_done, bus_a.bus_req, bus_a.ba_oe, bus_a.sser_n}),
              32'h01);
        check("arst_ba", 32'(bus_a.ba), 32'h0);
        check("arst_key", 32'({a_kd, a_kp}), 32'h0);
        for (int i = 0; i < 16; i++) shadow[i] = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_a(0, 99, 0, 0, 16'h1234, 16'hBEEF, 1'b0);

        run_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
